// File: rtl/conv1_scheduler_pkg.sv
// Shared constants, FSM state type and the (kernel,row,col) operation index
// used by both the issue and the write counters of the conv1 scheduler.
package conv_pkg;

    localparam int OUT_DIM   = 28;
    localparam int NKERN     = 2;
    localparam int KSIZE     = 5;
    localparam int TOTAL_OPS = OUT_DIM * OUT_DIM * NKERN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       kernel;
        logic [4:0] row;
        logic [4:0] col;
    } op_idx_t;

    // Row-major walk with the kernel index innermost; wraps to zero after the last op.
    function automatic op_idx_t op_next(input op_idx_t i, input int dim, input int nk);
        op_idx_t n;
        n = i;
        if (int'(i.kernel) + 1 < nk) begin
            n.kernel = i.kernel + 1'b1;
        end else begin
            n.kernel = 1'b0;
            if (int'(i.col) + 1 < dim) begin
                n.col = i.col + 5'd1;
            end else begin
                n.col = 5'd0;
                if (int'(i.row) + 1 < dim) n.row = i.row + 5'd1;
                else                       n.row = 5'd0;
            end
        end
        return n;
    endfunction

    function automatic logic op_is_last(input op_idx_t i, input int dim, input int nk);
        return (int'(i.kernel) == nk - 1) && (int'(i.row) == dim - 1) &&
               (int'(i.col) == dim - 1);
    endfunction

endpackage

// File: rtl/conv1_scheduler_fifo.sv
// Result FIFO between the convolution engine and the featuremap writer.
// Occupancy is a registered count so consumers can use it without touching pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
        else $error("sync_fifo: push into full fifo dropped");

endmodule

// File: rtl/conv1_scheduler.sv
// Layer-pass scheduler for conv1: issues window operations to the shared
// convolution engine under a credit limit and writes results back in order.
module conv1_scheduler
    import conv_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int OUT_DIM  = conv_pkg::OUT_DIM,
    parameter int NKERN    = conv_pkg::NKERN,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [4:0]          iss_row,
    output logic [4:0]          iss_col,
    output logic                iss_kernel,
    input  logic                res_valid,
    input  logic [BITWIDTH-1:0] res_data,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic                wr_kernel,
    output logic [4:0]          wr_row,
    output logic [4:0]          wr_col,
    output logic [BITWIDTH-1:0] wr_data
);

    // Handshakes: a transfer happens in a cycle where valid && ready; the
    // sender keeps valid high and its fields stable until that cycle.

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    state_t          state;
    state_t          state_nx;
    op_idx_t         iss_idx;
    op_idx_t         wr_idx;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic            iss_fire;
    logic            wr_fire;
    logic            iss_last;
    logic            wr_last;
    logic            res_taken;

    // Both terms are registered, so wr_ready never reaches iss_valid combinationally.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};

    assign iss_valid  = (state == RUN) && (credit_used < CREDITS);
    assign iss_fire   = iss_valid && iss_ready;
    assign wr_valid   = !fifo_empty;
    assign wr_fire    = wr_valid && wr_ready;
    assign iss_last   = op_is_last(iss_idx, OUT_DIM, NKERN);
    assign wr_last    = op_is_last(wr_idx, OUT_DIM, NKERN);
    assign res_taken  = res_valid && (inflight != '0);

    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);
    assign iss_row    = iss_idx.row;
    assign iss_col    = iss_idx.col;
    assign iss_kernel = iss_idx.kernel;
    assign wr_row     = wr_idx.row;
    assign wr_col     = wr_idx.col;
    assign wr_kernel  = wr_idx.kernel;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (iss_fire && iss_last) state_nx = DRAIN;
            DRAIN:   if (wr_fire && wr_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            iss_idx  <= '0;
            wr_idx   <= '0;
            inflight <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                iss_idx <= '0;
                wr_idx  <= '0;
            end else begin
                if (iss_fire) iss_idx <= op_next(iss_idx, OUT_DIM, NKERN);
                if (wr_fire)  wr_idx  <= op_next(wr_idx, OUT_DIM, NKERN);
            end
            case ({iss_fire, res_taken})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (BITWIDTH),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_valid),
        .din   (res_data),
        .pop   (wr_fire),
        .dout  (wr_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_conv1_scheduler.sv
// Bench for conv1_scheduler: engine model with configurable latency, random
// ready patterns, and a scoreboard of engine outputs in issue order.
module tb_conv1_scheduler;

    localparam int BW    = 8;
    localparam int DIM   = 28;
    localparam int NK    = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = DIM * DIM * NK;
    localparam int LIMIT = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          iss_ready = 1'b0;
    logic          res_valid = 1'b0;
    logic [BW-1:0] res_data = '0;
    logic          wr_ready = 1'b0;
    logic          busy, done, iss_valid, iss_kernel, wr_valid, wr_kernel;
    logic [4:0]    iss_row, iss_col, wr_row, wr_col;
    logic [BW-1:0] wr_data;

    always #5 clk = ~clk;

    conv1_scheduler #(
        .BITWIDTH (BW),
        .OUT_DIM  (DIM),
        .NKERN    (NK),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_row    (iss_row),
        .iss_col    (iss_col),
        .iss_kernel (iss_kernel),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_kernel  (wr_kernel),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int cyc = 0;
    int lat = 2;
    int iss_p = 100;
    int wr_p = 100;
    bit iss_hold = 0, wr_hold = 0, start_pulse = 0, start_on_done = 0;

    int            due_q[$];
    logic [BW-1:0] eng_q[$];
    logic [BW-1:0] exp_q[$];
    logic [10:0]   iss_q[$];
    logic [BW+10:0] wr_q[$];

    int done_cnt, done_busy_err, stab_err, max_out;
    bit prev_busy, prev_iss_stall, prev_wr_stall;
    logic [10:0]    prev_iss;
    logic [BW+10:0] prev_wr;

    // Expected {kernel,row,col} of the i-th operation of a pass.
    function automatic logic [10:0] addr_of(input int i);
        logic [10:0] a;
        a[10]  = 1'(i % NK);
        a[9:5] = 5'(i / (NK * DIM));
        a[4:0] = 5'((i / NK) % DIM);
        return a;
    endfunction

    function automatic int score_pass();
        int e = 0;
        if (iss_q.size() != TOTAL) e++;
        if (wr_q.size() != TOTAL) e++;
        for (int i = 0; i < iss_q.size() && i < TOTAL; i++)
            if (iss_q[i] !== addr_of(i)) e++;
        for (int i = 0; i < wr_q.size() && i < TOTAL && i < exp_q.size(); i++)
            if (wr_q[i] !== {addr_of(i), exp_q[i]}) e++;
        return e;
    endfunction

    task automatic new_pass();
        iss_q.delete(); wr_q.delete(); exp_q.delete();
        due_q.delete(); eng_q.delete();
        done_cnt = 0; done_busy_err = 0; stab_err = 0; max_out = 0;
    endtask

    // One clock: drive inputs at the falling edge, then observe and log the cycle.
    task automatic step();
        logic [BW-1:0] d;
        int outs;
        @(negedge clk);
        start = start_pulse;
        start_pulse = 0;
        res_valid = 1'b0;
        res_data = '0;
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            res_valid = 1'b1;
            res_data = eng_q.pop_front();
        end
        iss_ready = !iss_hold && (int'($urandom_range(99)) < iss_p);
        wr_ready  = !wr_hold && (int'($urandom_range(99)) < wr_p);
        #1;
        if (prev_iss_stall && (iss_valid !== 1'b1 || {iss_kernel, iss_row, iss_col} !== prev_iss))
            stab_err++;
        if (prev_wr_stall && (wr_valid !== 1'b1 ||
                              {wr_kernel, wr_row, wr_col, wr_data} !== prev_wr))
            stab_err++;
        if (iss_valid === 1'b1 && iss_ready) begin
            d = BW'($urandom);
            iss_q.push_back({iss_kernel, iss_row, iss_col});
            exp_q.push_back(d);
            due_q.push_back(cyc + lat);
            eng_q.push_back(d);
        end
        if (wr_valid === 1'b1 && wr_ready)
            wr_q.push_back({wr_kernel, wr_row, wr_col, wr_data});
        outs = iss_q.size() - wr_q.size();
        if (outs > max_out) max_out = outs;
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0 || !prev_busy) done_busy_err++;
            if (start_on_done) start = 1'b1;
        end
        prev_busy      = (busy === 1'b1);
        prev_iss_stall = (iss_valid === 1'b1) && !iss_ready;
        prev_wr_stall  = (wr_valid === 1'b1) && !wr_ready;
        prev_iss       = {iss_kernel, iss_row, iss_col};
        prev_wr        = {wr_kernel, wr_row, wr_col, wr_data};
        cyc++;
    endtask

    task automatic run_to_done(output int cycles);
        cycles = 0;
        while (done_cnt == 0 && cycles < LIMIT) begin
            step();
            cycles++;
        end
    endtask

    task automatic verify_pass(input string name);
        int e;
        e = score_pass();
        n_cmp++;
        if (done_cnt != 1) begin
            n_mis++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
        n_cmp++;
        if (e != 0) begin
            n_mis++;
            $display("FAIL %s scoreboard: %0d errors (issued %0d written %0d) want 0 errors, %0d each",
                     name, e, iss_q.size(), wr_q.size(), TOTAL);
        end
        n_cmp++;
        if (stab_err != 0) begin
            n_mis++;
            $display("FAIL %s stability: got %0d violations want 0", name, stab_err);
        end
        n_cmp++;
        if (done_busy_err != 0) begin
            n_mis++;
            $display("FAIL %s done_busy: got %0d bad done cycles want 0", name, done_busy_err);
        end
        n_cmp++;
        if (max_out > DEPTH) begin
            n_mis++;
            $display("FAIL %s outstanding: got %0d want <= %0d", name, max_out, DEPTH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({busy, done, iss_valid, wr_valid} !== 4'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: got %b want 0000", {busy, done, iss_valid, wr_valid});
        end
        n_cmp++;
        if ({iss_kernel, iss_row, iss_col} !== 11'd0) begin
            n_mis++;
            $display("FAIL reset_iss_addr: got %h want 000", {iss_kernel, iss_row, iss_col});
        end
        n_cmp++;
        if ({wr_kernel, wr_row, wr_col} !== 11'd0) begin
            n_mis++;
            $display("FAIL reset_wr_addr: got %h want 000", {wr_kernel, wr_row, wr_col});
        end
        n_cmp++;
        if (wr_data !== '0) begin
            n_mis++;
            $display("FAIL reset_wr_data: got %h want 00", wr_data);
        end
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({busy, iss_valid} !== 2'b00) begin
            n_mis++;
            $display("FAIL idle_no_start: got %b want 00", {busy, iss_valid});
        end
    endtask

    task automatic test_full_pass();
        int cycles;
        lat = 2; iss_p = 100; wr_p = 100;
        new_pass();
        start_pulse = 1;
        run_to_done(cycles);
        n_cmp++;
        if (cycles - 1 > TOTAL + lat + 3) begin
            n_mis++;
            $display("FAIL full_pass_time: got %0d cycles want <= %0d", cycles - 1, TOTAL + lat + 3);
        end
        step();
        n_cmp++;
        if ({busy, done, iss_valid, wr_valid} !== 4'b0) begin
            n_mis++;
            $display("FAIL full_pass_idle: got %b want 0000", {busy, done, iss_valid, wr_valid});
        end
        verify_pass("full_pass");
    endtask

    task automatic test_iss_stall();
        int k, bad, cycles;
        lat = 2; iss_p = 100; wr_p = 100;
        new_pass();
        start_pulse = 1;
        k = 0;
        while (iss_q.size() < 5 && k < 100) begin
            step();
            k++;
        end
        iss_hold = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (iss_valid !== 1'b1 || iss_row !== 5'd0 || iss_col !== 5'd2 || iss_kernel !== 1'b1)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_mis++;
            $display("FAIL iss_stall_hold: got %0d bad cycles (last r=%0d c=%0d k=%0d v=%b) want r=0 c=2 k=1 v=1",
                     bad, iss_row, iss_col, iss_kernel, iss_valid);
        end
        n_cmp++;
        if (iss_q.size() != 5) begin
            n_mis++;
            $display("FAIL iss_stall_count: got %0d issued want 5", iss_q.size());
        end
        iss_hold = 0;
        run_to_done(cycles);
        verify_pass("iss_stall");
    endtask

    task automatic test_wr_stall();
        int cycles;
        lat = 1; iss_p = 100; wr_p = 100;
        new_pass();
        wr_hold = 1;
        start_pulse = 1;
        for (int i = 0; i < 50; i++) step();
        n_cmp++;
        if (max_out != DEPTH) begin
            n_mis++;
            $display("FAIL wr_stall_outstanding: got %0d want %0d", max_out, DEPTH);
        end
        n_cmp++;
        if ({iss_valid, wr_valid} !== 2'b01) begin
            n_mis++;
            $display("FAIL wr_stall_valids: got %b want 01", {iss_valid, wr_valid});
        end
        wr_hold = 0;
        run_to_done(cycles);
        verify_pass("wr_stall");
    endtask

    task automatic test_start_ignored();
        int cycles;
        lat = 2; iss_p = 100; wr_p = 100;
        new_pass();
        start_pulse = 1;
        for (int i = 0; i < 100; i++) step();
        start_pulse = 1;
        start_on_done = 1;
        run_to_done(cycles);
        start_on_done = 0;
        for (int i = 0; i < 30; i++) step();
        n_cmp++;
        if ({busy, iss_valid} !== 2'b00) begin
            n_mis++;
            $display("FAIL start_ignored_idle: got %b want 00", {busy, iss_valid});
        end
        verify_pass("start_ignored");
    endtask

    task automatic test_reset_mid();
        int k, cycles;
        lat = 2; iss_p = 100; wr_p = 100;
        new_pass();
        start_pulse = 1;
        k = 0;
        while (iss_q.size() < 700 && k < 5000) begin
            step();
            k++;
        end
        rst = 1'b1;
        due_q.delete();
        eng_q.delete();
        step();
        n_cmp++;
        if ({busy, done, iss_valid, wr_valid, iss_kernel, iss_row, iss_col,
             wr_kernel, wr_row, wr_col, wr_data} !== '0) begin
            n_mis++;
            $display("FAIL reset_mid_outputs: got ctrl=%b iss=%h wr=%h data=%h want all zero",
                     {busy, done, iss_valid, wr_valid}, {iss_kernel, iss_row, iss_col},
                     {wr_kernel, wr_row, wr_col}, wr_data);
        end
        rst = 1'b0;
        new_pass();
        start_pulse = 1;
        run_to_done(cycles);
        verify_pass("reset_replay");
    endtask

    task automatic test_random();
        int cycles;
        string name;
        for (int p = 0; p < 3; p++) begin
            lat   = int'($urandom_range(3, 1));
            iss_p = int'($urandom_range(95, 40));
            wr_p  = int'($urandom_range(95, 40));
            new_pass();
            start_pulse = 1;
            run_to_done(cycles);
            name = $sformatf("random_pass%0d", p);
            verify_pass(name);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_iss_stall();
        test_wr_stall();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/conv1_scheduler.md
CONV1_SCHEDULER -- requirements
Module: conv1_scheduler

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: featuremap/result word width.
REQ-002 SHALL have parameter OUT_DIM, default 28: featuremap rows and columns.
REQ-003 SHALL have parameter NKERN, default 2: kernels per window position.
REQ-004 SHALL have parameter DEPTH, default 4: result FIFO depth, which is also the maximum number of in-flight operations.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin one full layer pass; sampled only in IDLE.
REQ-008 busy  out  1  high in RUN and DRAIN.
REQ-009 done  out  1  one-cycle pulse when the final featuremap word is accepted.
REQ-010 iss_valid/iss_ready  out/in  1/1  issue handshake to the shared convolution_point engine.
REQ-011 iss_row, iss_col  out  5 each  window origin; the engine reads padded image rows row..row+4 and columns col..col+4.
REQ-012 iss_kernel  out  1  kernel index.
REQ-013 res_valid, res_data  in  1, BITWIDTH  engine result, in issue order; no backpressure.
REQ-014 wr_valid/wr_ready  out/in  1/1  featuremap write handshake.
REQ-015 wr_kernel, wr_row, wr_col, wr_data  out  1, 5, 5, BITWIDTH  write address and data.

Function
REQ-016 Issue order SHALL be row-major with kernel innermost: (r,c,k) = (0,0,0), (0,0,1), (0,1,0), ... , (27,27,1), for 1568 operations in total.
REQ-017 SHALL use the FSM states IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN on the issue handshake of the last operation.
- DRAIN -> DONE on the write handshake of the last word.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 An issue SHALL occur only in a cycle with iss_valid && iss_ready.
- An issue advances the issue counter (k, then c, then r).
- iss_valid SHALL stay asserted and the issue fields SHALL stay stable until the handshake completes.
REQ-019 Credit rule: iss_valid SHALL be asserted only when (in-flight + FIFO occupancy) < DEPTH.
- In-flight = issued minus results received.
REQ-020 Each res_valid SHALL push res_data into the FIFO; a push in the same cycle as a credit-freeing pop SHALL be legal.
REQ-021 wr_valid SHALL equal FIFO non-empty; wr_data SHALL be the FIFO head.
- wr_kernel/wr_row/wr_col come from an independent write counter with the same ordering as the issue counter.
- The write counter advances on wr_valid && wr_ready.
REQ-022 wr_* signals SHALL hold stable while wr_valid && !wr_ready.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 A push into a full FIFO is a protocol error: the FSM SHALL drop it and a simulation assertion SHALL fire.
REQ-025 No combinational path SHALL exist from wr_ready to iss_valid.
- The credit check uses registered occupancy.
- The cost of this rule is one cycle of credit-return latency.
REQ-026 Minimum pass time with iss_ready=wr_ready=1 and engine latency L SHALL be at most 1568 + L + 3 cycles when DEPTH >= L+1.

Reset
REQ-027 On rst the FSM SHALL go to IDLE and all counters and FIFO pointers SHALL clear.
- busy=0, done=0, iss_valid=0, wr_valid=0.
- All address outputs = 0; wr_data = 0.
REQ-028 rst asserted mid-pass SHALL abandon the pass.
- Results arriving after rst deasserts SHALL be discarded by an environment requirement: the engine must also be reset.

Structure
REQ-029 The shared package conv_pkg SHALL hold:
- the OUT_DIM, NKERN and KSIZE=5 constants;
- TOTAL_OPS = OUT_DIM*OUT_DIM*NKERN;
- the FSM state enum;
- a packed struct {kernel,row,col} used by both counters.
REQ-030 The result FIFO SHALL be a sub-module, sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count).

Verification
REQ-031 Reset, then start with iss_ready=wr_ready=1 and engine latency 2 -> 1568 writes in order (0,0,0)..(1,27,27); a single done pulse; busy falls in the same cycle as the done pulse.
REQ-032 Hold iss_ready=0 for 10 cycles at op 5 -> iss_row=0, iss_col=2, iss_kernel=1 held stable throughout; no duplicate or skipped operations.
REQ-033 wr_ready=0 for 50 cycles with latency 1 -> at most 4 operations outstanding; no FIFO overflow assertion; all data written once wr_ready returns.
REQ-034 Pulse start during RUN and again during DONE -> ignored; exactly one pass completes.
REQ-035 Assert rst at op 700 -> next cycle all outputs at reset values; a new start replays from (0,0,0).
REQ-036 Randomized iss_ready/wr_ready over 3 passes -> written data matches a scoreboard of engine outputs indexed by issue order.
